// File: rtl/microcode_sequencer_pkg.sv
// Shared microword layout, sequencing encodings and FSM states for the
// microcode sequencer and the bus executor decode.
package microcode_sequencer_pkg;

   typedef enum logic [1:0] {
      SEQ_NEXT   = 2'b00,
      SEQ_JUMP   = 2'b01,
      SEQ_BRANCH = 2'b10,
      SEQ_END    = 2'b11
   } seq_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [7:0] BUS_NOP = 8'h00;

   // Word is {w_addr[8], r_addr[8], seq[2], wait[1], target[uw]}, MSB first.
   function automatic int word_width(input int uw);
      return uw + 19;
   endfunction

   function automatic int w_lsb(input int uw);
      return uw + 11;
   endfunction

   function automatic int r_lsb(input int uw);
      return uw + 3;
   endfunction

   function automatic int seq_lsb(input int uw);
      return uw + 1;
   endfunction

   function automatic int wait_pos(input int uw);
      return uw;
   endfunction

endpackage

// File: rtl/microcode_sequencer_ucode_store.sv
// Microcode store: register array with a synchronous write port and a
// combinational read port. Contents are deliberately left unreset.
module microcode_sequencer_ucode_store
   import microcode_sequencer_pkg::*;
#(
   parameter int UPC_WIDTH = 6
) (
   input  logic                              clk,
   input  logic                              we,
   input  logic [UPC_WIDTH-1:0]              waddr,
   input  logic [word_width(UPC_WIDTH)-1:0]  wdata,
   input  logic [UPC_WIDTH-1:0]              raddr,
   output logic [word_width(UPC_WIDTH)-1:0]  rdata
);

   localparam int DW = word_width(UPC_WIDTH);

   logic [DW-1:0] mem_r [2**UPC_WIDTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end else begin
         mem_r[waddr] <= mem_r[waddr];
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps a loadable store, issuing one bus transfer per
// step, with branching, ready-wait stalls and a runaway-step watchdog.
module microcode_sequencer
   import microcode_sequencer_pkg::*;
#(
   parameter int UPC_WIDTH = 6,
   parameter int MAX_STEPS = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [UPC_WIDTH-1:0]   entry_upc,
   input  logic                   cond,
   input  logic                   ready,
   input  logic                   load_we,
   input  logic [UPC_WIDTH-1:0]   load_addr,
   input  logic [UPC_WIDTH+18:0]  load_data,
   output logic [7:0]             w_addr,
   output logic [7:0]             r_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   fault
);

   localparam int DW     = word_width(UPC_WIDTH);
   localparam int STEP_W = $clog2(MAX_STEPS + 1);
   localparam int W_LSB  = w_lsb(UPC_WIDTH);
   localparam int R_LSB  = r_lsb(UPC_WIDTH);
   localparam int S_LSB  = seq_lsb(UPC_WIDTH);
   localparam int WT_POS = wait_pos(UPC_WIDTH);

   state_e                state_r;
   logic [UPC_WIDTH-1:0]  upc_r;
   logic [STEP_W-1:0]     steps_r;
   logic [7:0]            w_addr_r;
   logic [7:0]            r_addr_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  fault_r;

   logic [DW-1:0]         word_s;
   logic                  store_we_s;
   logic [UPC_WIDTH-1:0]  upc_inc_s;
   seq_e                  seq_s;
   logic                  stall_s;
   logic                  wd_trip_s;

   // Writes are accepted only while no routine is running
   assign store_we_s = load_we & (state_r == ST_IDLE);

   microcode_sequencer_ucode_store #(
      .UPC_WIDTH (UPC_WIDTH)
   ) u_ucode_store (
      .clk   (clk),
      .we    (store_we_s),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (upc_r),
      .rdata (word_s)
   );

   // Decode of the current microword
   always_comb begin
      upc_inc_s = upc_r + UPC_WIDTH'(1'b1);
      seq_s     = seq_e'(word_s[S_LSB +: 2]);
      stall_s   = word_s[WT_POS] & ~ready;
      wd_trip_s = (steps_r == STEP_W'(MAX_STEPS));
   end

   // Sequencer FSM, micro-PC, step counter and registered bus outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         upc_r    <= {UPC_WIDTH{1'b0}};
         steps_r  <= {STEP_W{1'b0}};
         w_addr_r <= BUS_NOP;
         r_addr_r <= BUS_NOP;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         fault_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               w_addr_r <= BUS_NOP;
               r_addr_r <= BUS_NOP;
               done_r   <= 1'b0;
               fault_r  <= 1'b0;
               if (start) begin
                  upc_r   <= entry_upc;
                  steps_r <= {STEP_W{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= ST_EXEC;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_EXEC: begin
               done_r <= 1'b0;
               if (stall_s) begin
                  w_addr_r <= BUS_NOP;
                  r_addr_r <= BUS_NOP;
                  fault_r  <= 1'b0;
               end else if (wd_trip_s) begin
                  // Runaway routine: drop this step and abort without done
                  w_addr_r <= BUS_NOP;
                  r_addr_r <= BUS_NOP;
                  fault_r  <= 1'b1;
                  busy_r   <= 1'b0;
                  state_r  <= ST_IDLE;
               end else begin
                  w_addr_r <= word_s[W_LSB +: 8];
                  r_addr_r <= word_s[R_LSB +: 8];
                  fault_r  <= 1'b0;
                  steps_r  <= steps_r + STEP_W'(1'b1);
                  case (seq_s)
                     SEQ_NEXT:   upc_r <= upc_inc_s;
                     SEQ_JUMP:   upc_r <= word_s[UPC_WIDTH-1:0];
                     SEQ_BRANCH: upc_r <= cond ? word_s[UPC_WIDTH-1:0] : upc_inc_s;
                     SEQ_END:    state_r <= ST_DONE;
                     default:    upc_r <= upc_inc_s;
                  endcase
               end
            end
            ST_DONE: begin
               w_addr_r <= BUS_NOP;
               r_addr_r <= BUS_NOP;
               done_r   <= 1'b1;
               fault_r  <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= ST_IDLE;
            end
            default: begin
               w_addr_r <= BUS_NOP;
               r_addr_r <= BUS_NOP;
               done_r   <= 1'b0;
               fault_r  <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_addr = w_addr_r;
   assign r_addr = r_addr_r;
   assign busy   = busy_r;
   assign done   = done_r;
   assign fault  = fault_r;

endmodule
